dot_product_ctrl: RTL and testbench

Sequencer for the dot-product accelerator. It takes the configuration registers held by the AXI-Lite register slave: start, vector A base, vector B base, length and output address. It fetches A[i] and B[i] over a single-outstanding memory read port, multiply-accumulates the pairs, and writes the result to the output address. It returns busy/done/error/overflow status for the status register, plus an interrupt pulse.

---
 rtl/dot_pkg.sv | 23 ++
 rtl/dot_product_ctrl_mac.sv | 35 +++
 rtl/dot_product_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_dot_product_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product sequencer.
package dot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_WAIT_A,
    ST_RD_B,
    ST_WAIT_B,
    ST_MAC,
    ST_WR,
    ST_FIN
  } dot_state_t;

  localparam int unsigned STS_BUSY = 0;
  localparam int unsigned STS_DONE = 1;
  localparam int unsigned STS_ERR  = 2;
  localparam int unsigned STS_OVF  = 3;

  localparam int unsigned DOT_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_ELEM = DOT_DATA_WIDTH / 8;

endpackage

// File: rtl/dot_product_ctrl_mac.sv
// Registered signed multiply-accumulate; the sum is visible the cycle after i_en.
module dot_mac #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]  w_a_ext;
  logic signed [PW-1:0]  w_b_ext;
  logic signed [PW-1:0]  w_prod;
  logic [ACC_WIDTH-1:0]  r_acc;

  // Operands widened first so the full signed product is kept.
  assign w_a_ext = PW'($signed(i_a));
  assign w_b_ext = PW'($signed(i_b));
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_acc <= '0;
    else if (i_clr)  r_acc <= '0;
    else if (i_en)   r_acc <= r_acc + ACC_WIDTH'(w_prod);
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: fetch A[i]/B[i], accumulate, write result, report status.
// Optional cycle counter on perf_cycles when DOT_PERF_CNT_EN is defined.
module dot_product_ctrl
  import dot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned MAX_LEN    = 65536
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_a_base,
  input  logic [ADDR_WIDTH-1:0] cfg_b_base,
  input  logic [31:0]           cfg_len,
  input  logic [ADDR_WIDTH-1:0] cfg_out_addr,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_gnt,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_gnt,
  output logic [31:0]           sts_word,
  output logic                  irq,
  output logic [31:0]           perf_cycles
);

  // Package stride scaled to this instance's element width.
  localparam int unsigned ELEM_BYTES = BYTES_PER_ELEM * DATA_WIDTH / DOT_DATA_WIDTH;

  dot_state_t            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_a_base, r_b_base, r_out_addr, r_rd_addr;
  logic [31:0]           r_len, r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_a, r_b;
  logic                  r_busy, r_done, r_err, r_ovf, r_irq, r_pend, r_rd_req, r_wr_req;
  logic                  w_busy_nxt, w_done_nxt, w_err_nxt, w_ovf_nxt, w_irq_nxt, w_pend_nxt;
  logic                  w_rd_req_nxt, w_wr_req_nxt, w_start_acc, w_cap_a, w_cap_b;
  logic                  w_mac_en, w_mac_clr, w_fin_enter, w_abort_exit, w_len_bad, w_acc_ovf;
  logic [ADDR_WIDTH-1:0] w_rd_base, w_rd_addr_nxt;
  logic [ACC_WIDTH-1:0]  w_acc;

  dot_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_acc (w_acc)
  );

  assign w_len_bad = (cfg_len == 32'd0) || (cfg_len > MAX_LEN);
  // Result fits in DATA_WIDTH only if all bits above the sign bit match it.
  assign w_acc_ovf = (w_acc[ACC_WIDTH-1:DATA_WIDTH-1] != '0) &&
                     (w_acc[ACC_WIDTH-1:DATA_WIDTH-1] != '1);
  assign w_rd_addr_nxt = w_rd_base + ADDR_WIDTH'(w_idx_nxt) * ADDR_WIDTH'(ELEM_BYTES);

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_err_nxt    = r_err;
    w_ovf_nxt    = r_ovf;
    w_pend_nxt   = r_pend;
    w_irq_nxt    = 1'b0;
    w_rd_req_nxt = 1'b0;
    w_wr_req_nxt = 1'b0;
    w_rd_base    = r_a_base;
    w_start_acc  = 1'b0;
    w_cap_a      = 1'b0;
    w_cap_b      = 1'b0;
    w_mac_en     = 1'b0;
    w_mac_clr    = 1'b0;
    w_fin_enter  = 1'b0;
    w_abort_exit = 1'b0;
    unique case (r_state)
      ST_IDLE: if (cfg_start) begin
        w_start_acc = 1'b1;
        w_mac_clr   = 1'b1;
        w_idx_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_pend_nxt  = 1'b0;
        if (w_len_bad) begin
          w_err_nxt   = 1'b1;
          w_fin_enter = 1'b1;
        end else begin
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ST_RD_A;
          w_rd_req_nxt = 1'b1;
          w_rd_base    = cfg_a_base;
        end
      end
      ST_RD_A: begin
        if (cfg_abort)       w_abort_exit = 1'b1;
        else if (mem_rd_gnt) w_state_nxt  = ST_WAIT_A;
        else                 w_rd_req_nxt = 1'b1;
      end
      ST_WAIT_A: begin
        if (mem_rd_valid) begin
          w_cap_a = 1'b1;
          if (r_pend || cfg_abort) w_abort_exit = 1'b1;
          else begin
            w_state_nxt  = ST_RD_B;
            w_rd_req_nxt = 1'b1;
            w_rd_base    = r_b_base;
          end
        end else if (cfg_abort) w_pend_nxt = 1'b1;
      end
      ST_RD_B: begin
        w_rd_base = r_b_base;
        if (cfg_abort)       w_abort_exit = 1'b1;
        else if (mem_rd_gnt) w_state_nxt  = ST_WAIT_B;
        else                 w_rd_req_nxt = 1'b1;
      end
      ST_WAIT_B: begin
        if (mem_rd_valid) begin
          w_cap_b = 1'b1;
          if (r_pend || cfg_abort) w_abort_exit = 1'b1;
          else                     w_state_nxt  = ST_MAC;
        end else if (cfg_abort) w_pend_nxt = 1'b1;
      end
      ST_MAC: begin
        if (cfg_abort) w_abort_exit = 1'b1;
        else begin
          w_mac_en  = 1'b1;
          w_idx_nxt = r_idx + 32'd1;
          if (r_idx == r_len - 32'd1) begin
            w_state_nxt  = ST_WR;
            w_wr_req_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_RD_A;
            w_rd_req_nxt = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (cfg_abort) w_abort_exit = 1'b1;
        else begin
          w_ovf_nxt = w_acc_ovf;
          if (mem_wr_gnt) w_fin_enter  = 1'b1;
          else            w_wr_req_nxt = 1'b1;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_fin_enter) begin
      w_state_nxt = ST_FIN;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b1;
      w_irq_nxt   = 1'b1;
    end
    // Abort leaves an error with no completion and no further memory traffic.
    if (w_abort_exit) begin
      w_state_nxt  = ST_IDLE;
      w_busy_nxt   = 1'b0;
      w_err_nxt    = 1'b1;
      w_done_nxt   = 1'b0;
      w_pend_nxt   = 1'b0;
      w_rd_req_nxt = 1'b0;
      w_wr_req_nxt = 1'b0;
      w_mac_en     = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_a_base   <= '0;
      r_b_base   <= '0;
      r_out_addr <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_irq      <= 1'b0;
      r_pend     <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_req   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_ovf    <= w_ovf_nxt;
      r_irq    <= w_irq_nxt;
      r_pend   <= w_pend_nxt;
      r_rd_req <= w_rd_req_nxt;
      r_wr_req <= w_wr_req_nxt;
      if (w_rd_req_nxt) r_rd_addr <= w_rd_addr_nxt;
      if (w_cap_a)      r_a <= mem_rd_data;
      if (w_cap_b)      r_b <= mem_rd_data;
      if (w_start_acc) begin
        r_a_base   <= cfg_a_base;
        r_b_base   <= cfg_b_base;
        r_len      <= cfg_len;
        r_out_addr <= cfg_out_addr;
      end
    end
  end

  assign mem_rd_req  = r_rd_req;
  assign mem_rd_addr = r_rd_addr;
  assign mem_wr_req  = r_wr_req;
  assign mem_wr_addr = r_out_addr;
  assign mem_wr_data = w_acc[DATA_WIDTH-1:0];
  assign irq         = r_irq;

  always_comb begin
    sts_word           = '0;
    sts_word[STS_BUSY] = r_busy;
    sts_word[STS_DONE] = r_done;
    sts_word[STS_ERR]  = r_err;
    sts_word[STS_OVF]  = r_ovf;
  end

`ifdef DOT_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)         r_perf <= '0;
    else if (w_start_acc) r_perf <= '0;
    else if (r_busy)      r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl with a delay-configurable memory responder.
module tb_dot_product_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [31:0] cfg_a_base = '0, cfg_b_base = '0, cfg_len = '0, cfg_out_addr = '0;
  logic        mem_rd_req, mem_rd_gnt, mem_rd_valid, mem_wr_req, mem_wr_gnt, irq;
  logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data, sts_word, perf_cycles;

  dot_product_ctrl dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_len(cfg_len),
    .cfg_out_addr(cfg_out_addr), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_gnt(mem_rd_gnt), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_gnt(mem_wr_gnt), .sts_word(sts_word), .irq(irq), .perf_cycles(perf_cycles)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Memory responder
  logic [31:0] mem [logic [31:0]];
  int unsigned gnt_dly = 0, vld_dly = 1;
  int unsigned r_gwait = 0, r_vcnt = 0;
  logic        r_pend = 1'b0;
  logic [31:0] r_pdata = '0;

  assign mem_rd_gnt   = mem_rd_req && (r_gwait == gnt_dly);
  assign mem_rd_valid = r_pend && (r_vcnt == 0);
  assign mem_rd_data  = r_pdata;
  assign mem_wr_gnt   = mem_wr_req;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_gwait <= 0; r_pend <= 1'b0; r_vcnt <= 0; r_pdata <= '0;
    end else begin
      r_gwait <= (mem_rd_req && !mem_rd_gnt) ? r_gwait + 1 : 0;
      if (mem_rd_valid) r_pend <= 1'b0;
      else if (r_pend)  r_vcnt <= r_vcnt - 1;
      if (mem_rd_req && mem_rd_gnt) begin
        r_pend  <= 1'b1;
        r_vcnt  <= vld_dly - 1;
        r_pdata <= mem.exists(mem_rd_addr) ? mem[mem_rd_addr] : 32'hDEAD_BEEF;
      end
    end
  end

  // Monitors
  logic [31:0] rd_log[$], wr_addr_q[$], wr_data_q[$];
  int unsigned irq_cnt = 0, stab_bad = 0;
  logic        r_prev_stall = 1'b0;
  logic [31:0] r_prev_addr = '0;

  always @(posedge ACLK) begin
    if (ARESETN && mem_rd_req && mem_rd_gnt) rd_log.push_back(mem_rd_addr);
    if (ARESETN && mem_wr_req && mem_wr_gnt) begin
      wr_addr_q.push_back(mem_wr_addr);
      wr_data_q.push_back(mem_wr_data);
    end
    if (ARESETN && r_prev_stall && (!mem_rd_req || mem_rd_addr != r_prev_addr))
      stab_bad <= stab_bad + 1;
    r_prev_stall <= ARESETN && mem_rd_req && !mem_rd_gnt;
    r_prev_addr  <= mem_rd_addr;
  end

  always @(negedge ACLK) if (ARESETN && irq) irq_cnt <= irq_cnt + 1;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] len,
                           input logic [31:0] outa, output int unsigned s);
    @(posedge ACLK); #1;
    cfg_a_base = a; cfg_b_base = b; cfg_len = len; cfg_out_addr = outa; cfg_start = 1'b1;
    s = cyc;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_irq(input int unsigned s, input int budget, output logic found,
                          output int unsigned lat);
    found = 1'b0; lat = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge ACLK);
      if (irq) begin found = 1'b1; lat = cyc - s; end
    end
  endtask

  task automatic wait_gnt(input logic [31:0] addr, input int budget, output logic found);
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge ACLK);
      if (mem_rd_req && mem_rd_gnt && mem_rd_addr == addr) found = 1'b1;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  initial begin
    int unsigned s, lat, rb, wb, ib;
    logic        found;
    logic [31:0] exp_rd [6];

    // Reset values
    settle(2);
    chk("rst_sts", sts_word, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rd_req", mem_rd_req, 0);
    chk("rst_wr_req", mem_wr_req, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_perf", perf_cycles, 0);
    ARESETN = 1'b1;

    // 1: [1,2,3].[4,5,6] = 32
    mem[32'h1000] = 1; mem[32'h1004] = 2; mem[32'h1008] = 3;
    mem[32'h2000] = 4; mem[32'h2004] = 5; mem[32'h2008] = 6;
    rb = rd_log.size(); wb = wr_addr_q.size(); ib = irq_cnt;
    start_run(32'h1000, 32'h2000, 3, 32'h100, s);
    wait_irq(s, 200, found, lat);
    chk("t1_irq_seen", found, 1);
    chk("t1_irq_lat", lat, 17);
    settle(2);
    exp_rd = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
    chk("t1_nrd", rd_log.size() - rb, 6);
    for (int i = 0; i < 6; i++) chk("t1_rd_addr", rd_log[rb + i], exp_rd[i]);
    chk("t1_nwr", wr_addr_q.size() - wb, 1);
    chk("t1_wr_addr", wr_addr_q[wb], 32'h100);
    chk("t1_wr_data", wr_data_q[wb], 32'h20);
    chk("t1_nirq", irq_cnt - ib, 1);
    chk("t1_sts", sts_word, 32'h2);

    // 2: -2 * 3
    mem[32'h1000] = 32'hFFFF_FFFE; mem[32'h2000] = 3;
    wb = wr_addr_q.size();
    start_run(32'h1000, 32'h2000, 1, 32'h104, s);
    wait_irq(s, 100, found, lat);
    chk("t2_irq_lat", lat, 7);
    settle(2);
    chk("t2_wr_addr", wr_addr_q[wb], 32'h104);
    chk("t2_wr_data", wr_data_q[wb], 32'hFFFF_FFFA);
    chk("t2_sts", sts_word, 32'h2);

    // 3: overflowing accumulation
    mem[32'h1000] = 32'h7FFF_FFFF; mem[32'h1004] = 32'h7FFF_FFFF;
    mem[32'h2000] = 32'h7FFF_FFFF; mem[32'h2004] = 32'h7FFF_FFFF;
    wb = wr_addr_q.size();
    start_run(32'h1000, 32'h2000, 2, 32'h100, s);
    wait_irq(s, 100, found, lat);
    chk("t3_irq_lat", lat, 12);
    settle(2);
    chk("t3_wr_data", wr_data_q[wb], 32'h2);
    chk("t3_sts", sts_word, 32'hA);

    // 4: illegal lengths
    rb = rd_log.size(); ib = irq_cnt;
    start_run(32'h1000, 32'h2000, 0, 32'h100, s);
    wait_irq(s, 20, found, lat);
    chk("t4_len0_lat", lat, 1);
    settle(2);
    chk("t4_len0_sts", sts_word, 32'h6);
    start_run(32'h1000, 32'h2000, 32'd65537, 32'h100, s);
    wait_irq(s, 20, found, lat);
    chk("t4_lenmax_lat", lat, 1);
    settle(2);
    chk("t4_lenmax_sts", sts_word, 32'h6);
    chk("t4_nrd", rd_log.size() - rb, 0);
    chk("t4_nirq", irq_cnt - ib, 2);

    // 5: slow memory, ignored restart, abort while waiting on B[2]
    for (int i = 0; i < 4; i++) begin
      mem[32'h1000 + 32'(4 * i)] = 32'(i + 1);
      mem[32'h2000 + 32'(4 * i)] = 32'(i + 5);
    end
    gnt_dly = 3; vld_dly = 2;
    rb = rd_log.size(); wb = wr_addr_q.size(); ib = irq_cnt;
    start_run(32'h1000, 32'h2000, 4, 32'h100, s);
    settle(2);
    @(posedge ACLK); #1;
    cfg_start = 1'b1; cfg_len = 1; cfg_a_base = 32'h3000;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    wait_gnt(32'h2008, 400, found);
    chk("t5_gnt_b2_seen", found, 1);
    @(posedge ACLK); #1;
    cfg_abort = 1'b1;
    @(posedge ACLK); #1;
    cfg_abort = 1'b0;
    @(negedge ACLK);
    chk("t5_pending_busy", sts_word, 32'h1);
    settle(4);
    chk("t5_sts", sts_word, 32'h4);
    chk("t5_nrd", rd_log.size() - rb, 6);
    chk("t5_rd2_addr", rd_log[rb + 2], 32'h1004);
    chk("t5_rd5_addr", rd_log[rb + 5], 32'h2008);
    chk("t5_nwr", wr_addr_q.size() - wb, 0);
    chk("t5_nirq", irq_cnt - ib, 0);
    chk("t5_stable", stab_bad, 0);
    chk("t5_rd_req_idle", mem_rd_req, 0);

    // 6: reset in WAIT_A, then a clean single-element run
    gnt_dly = 0; vld_dly = 1;
    start_run(32'h1000, 32'h2000, 2, 32'h100, s);
    wait_gnt(32'h1000, 50, found);
    chk("t6_gnt_seen", found, 1);
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk("t6_rst_sts", sts_word, 0);
    chk("t6_rst_rd_req", mem_rd_req, 0);
    chk("t6_rst_rd_addr", mem_rd_addr, 0);
    chk("t6_rst_wr_data", mem_wr_data, 0);
    chk("t6_rst_irq", irq, 0);
    settle(1);
    ARESETN = 1'b1;
    wb = wr_addr_q.size();
    start_run(32'h1000, 32'h2000, 1, 32'h108, s);
    wait_irq(s, 100, found, lat);
    chk("t6_irq_lat", lat, 7);
    settle(2);
    chk("t6_wr_addr", wr_addr_q[wb], 32'h108);
    chk("t6_wr_data", wr_data_q[wb], 32'h5);
    chk("t6_sts", sts_word, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
